// File: rtl/axi4lite_write_slave_q_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) for the queued write slave.
// The slave modport faces the interconnect; the master modport drives it.
interface axi4lite_write_slave_q_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    output awready, wready,
    output bvalid, bresp
  );

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    input  awready, wready,
    input  bvalid, bresp
  );
endinterface

// File: rtl/axi4lite_write_slave_q.sv
// AXI4-Lite write slave: AW/W hold registers, range-checked command
// queue, one-cycle byte-enable strobe to the backend, in-order B responses.
module axi4lite_write_slave_q #(
  parameter int              DATA_W = 32,
  parameter int              ADDR_W = 32,
  parameter int              DEPTH  = 4,
  parameter longint unsigned BASE   = 0,
  parameter longint unsigned SIZE   = 4096
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  axi4lite_write_slave_q_if.slave     s,
  input  logic                        stall,
  output logic [DATA_W/8-1:0]         en,
  output logic [ADDR_W-1:0]           addr,
  output logic [DATA_W-1:0]           data,
  output logic [$clog2(DEPTH+1)-1:0]  pending
);

  localparam int SW  = DATA_W / 8;
  localparam int LSB = $clog2(SW);
  localparam int PW  = $clog2(DEPTH + 1);
  localparam int QW  = $clog2(DEPTH);

  localparam logic [PW-1:0]   FULL = PW'(DEPTH);
  localparam logic [ADDR_W:0] LO   = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0] HI   = LO + (ADDR_W+1)'(SIZE);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [SW-1:0]     st;
    logic [1:0]        r;
  } entry_t;

  entry_t            q [DEPTH];
  logic [QW-1:0]     wr_ptr;
  logic [QW-1:0]     rd_ptr;

  logic              aw_full;
  logic              w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [SW-1:0]     w_strb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              push;
  logic              pop;
  logic              aw_full_d;
  logic              w_full_d;
  logic [ADDR_W:0]   a_x;
  logic              dec_err;
  logic              mis;
  logic [1:0]        resp_c;
  logic              unused_prot;

  assign unused_prot = ^s.awprot;

  assign aw_hs = s.awvalid & s.awready;
  assign w_hs  = s.wvalid & s.wready;

  // Full test uses the pre-edge occupancy: no bypass on a same-cycle pop.
  assign push = aw_full & w_full & (pending < FULL);
  assign pop  = (pending != '0) & ~stall & (~s.bvalid | s.bready);

  assign aw_full_d = push ? 1'b0 : (aw_full | aw_hs);
  assign w_full_d  = push ? 1'b0 : (w_full | w_hs);

  assign a_x     = {1'b0, aw_addr_q};
  assign dec_err = (a_x < LO) | (a_x >= HI);
  assign mis     = aw_addr_q[LSB-1:0] != '0;

  always_comb begin
    resp_c = OKAY;
    priority case (1'b1)
      dec_err: resp_c = DECERR;
      mis:     resp_c = SLVERR;
      default: resp_c = OKAY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      s.awready <= 1'b0;
      s.wready  <= 1'b0;
      s.bvalid  <= 1'b0;
      s.bresp   <= OKAY;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pending   <= '0;
      en        <= '0;
      addr      <= '0;
      data      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      aw_full   <= aw_full_d;
      w_full    <= w_full_d;
      s.awready <= ~aw_full_d;
      s.wready  <= ~w_full_d;

      if (aw_hs) begin
        aw_addr_q <= s.awaddr;
      end
      if (w_hs) begin
        w_data_q <= s.wdata;
        w_strb_q <= s.wstrb;
      end

      if (push) begin
        q[wr_ptr] <= '{a: aw_addr_q, d: w_data_q,
                       st: w_strb_q, r: resp_c};
        wr_ptr    <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        addr     <= q[rd_ptr].a;
        data     <= q[rd_ptr].d;
        en       <= (q[rd_ptr].r == OKAY) ? q[rd_ptr].st : '0;
        s.bvalid <= 1'b1;
        s.bresp  <= q[rd_ptr].r;
      end else begin
        en <= '0;
        if (s.bready) begin
          s.bvalid <= 1'b0;
        end
      end

      unique case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_write_slave_q.sv
// Scoreboard bench: 32-bit and 64-bit slaves, expected responses queued
// at issue time and checked by per-DUT monitors on each new B beat.
module tb_axi4lite_write_slave_q;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic        stall;
  logic        stall64;
  logic [3:0]  en32;
  logic [31:0] addr32;
  logic [31:0] data32;
  logic [2:0]  pend32;
  logic [7:0]  en64;
  logic [31:0] addr64;
  logic [63:0] data64;
  logic [2:0]  pend64;

  axi4lite_write_slave_q_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  axi4lite_write_slave_q_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  axi4lite_write_slave_q #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4), .BASE(0), .SIZE(4096)
  ) u32 (
    .aclk(aclk), .aresetn(aresetn), .s(b32), .stall(stall),
    .en(en32), .addr(addr32), .data(data32), .pending(pend32)
  );

  axi4lite_write_slave_q #(
    .DATA_W(64), .ADDR_W(32), .DEPTH(4), .BASE(0), .SIZE(4096)
  ) u64 (
    .aclk(aclk), .aresetn(aresetn), .s(b64), .stall(stall64),
    .en(en64), .addr(addr64), .data(data64), .pending(pend64)
  );

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  en;
    logic [1:0]  r;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  bit prev_bv;
  bit prev_hs;
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_bv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (b32.bvalid && !(prev_bv && !prev_hs)) begin
        if (q32.size() == 0) begin
          timeout("unexpected_resp32");
        end else begin
          exp_t e;
          e = q32.pop_front();
          chk("bresp32", b32.bresp, e.r);
          chk("en32", en32, e.en);
          chk("addr32", addr32, e.a);
          chk("data32", data32, e.d);
        end
      end else begin
        chk("en32_idle", en32, 0);
      end
      prev_bv = b32.bvalid;
      prev_hs = b32.bvalid & b32.bready;
    end
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      if (b64.bvalid) begin
        if (q64.size() == 0) begin
          timeout("unexpected_resp64");
        end else begin
          exp_t e;
          e = q64.pop_front();
          chk("bresp64", b64.bresp, e.r);
          chk("en64", en64, e.en);
          chk("addr64", addr64, e.a);
          chk("data64", data64, e.d);
        end
      end else begin
        chk("en64_idle", en64, 0);
      end
    end
  end

  task automatic wr32(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, input int aw_d, input int w_d,
                      input logic [3:0] ex_en, input logic [1:0] ex_r);
    exp_t e;
    e = '{a: a, d: {32'h0, d}, en: {4'h0, ex_en}, r: ex_r};
    q32.push_back(e);
    fork
      begin
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        repeat (aw_d) begin @(posedge aclk); #1; end
        b32.awvalid = 1'b1;
        b32.awaddr  = a;
        while (!ok && n < 300) begin
          @(posedge aclk);
          ok = b32.awready;
          n++;
        end
        #1 b32.awvalid = 1'b0;
        if (!ok) timeout("aw_handshake");
      end
      begin
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        repeat (w_d) begin @(posedge aclk); #1; end
        b32.wvalid = 1'b1;
        b32.wdata  = d;
        b32.wstrb  = st;
        while (!ok && n < 300) begin
          @(posedge aclk);
          ok = b32.wready;
          n++;
        end
        #1 b32.wvalid = 1'b0;
        if (!ok) timeout("w_handshake");
      end
    join
  endtask

  task automatic wr64(input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] st, input logic [7:0] ex_en,
                      input logic [1:0] ex_r);
    int  n;
    bit  aw_ok;
    bit  w_ok;
    exp_t e;
    e = '{a: a, d: d, en: ex_en, r: ex_r};
    q64.push_back(e);
    n = 0;
    aw_ok = 1'b0;
    w_ok = 1'b0;
    b64.awvalid = 1'b1;
    b64.awaddr  = a;
    b64.wvalid  = 1'b1;
    b64.wdata   = d;
    b64.wstrb   = st;
    while (!(aw_ok && w_ok) && n < 300) begin
      @(posedge aclk);
      if (b64.awready && b64.awvalid) aw_ok = 1'b1;
      if (b64.wready && b64.wvalid) w_ok = 1'b1;
      #1;
      if (aw_ok) b64.awvalid = 1'b0;
      if (w_ok) b64.wvalid = 1'b0;
      n++;
    end
    if (!(aw_ok && w_ok)) timeout("hs64");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 500) begin
      @(posedge aclk);
      n++;
    end
    if (q32.size() != 0 || q64.size() != 0) timeout("drain");
    repeat (3) @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn     = 1'b0;
    stall       = 1'b0;
    stall64     = 1'b0;
    b32.awvalid = 1'b0;
    b32.awaddr  = '0;
    b32.awprot  = '0;
    b32.wvalid  = 1'b0;
    b32.wdata   = '0;
    b32.wstrb   = '0;
    b32.bready  = 1'b1;
    b64.awvalid = 1'b0;
    b64.awaddr  = '0;
    b64.awprot  = '0;
    b64.wvalid  = 1'b0;
    b64.wdata   = '0;
    b64.wstrb   = '0;
    b64.bready  = 1'b1;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", b32.awready, 0);
    chk("rst_wready", b32.wready, 0);
    chk("rst_bvalid", b32.bvalid, 0);
    chk("rst_pending", pend32, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("awready_after_rst", b32.awready, 1);
    chk("wready_after_rst", b32.wready, 1);

    // single write, then exact T+2 latency of the strobe
    wr32(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 4'hF, 2'b00);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk("latency_en", en32, 4'hF);
    chk("latency_bvalid", b32.bvalid, 1);
    drain();

    wr32(32'h2, 32'hCAFEF00D, 4'hF, 2, 0, 4'h0, 2'b10);
    wr32(32'h1000, 32'h12345678, 4'hF, 0, 0, 4'h0, 2'b11);
    wr32(32'h14, 32'h00000005, 4'h0, 0, 1, 4'h0, 2'b00);
    wr32(32'h18, 32'hA5A5A5A5, 4'h3, 1, 0, 4'h3, 2'b00);
    drain();

    // backend stalled: 4 queued plus one held pair
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr32(32'h20 + 4 * i, 32'h100 + i, 4'hF, 0, 0, 4'hF, 2'b00);
    end
    fork
      wr32(32'h34, 32'h105, 4'hF, 0, 0, 4'hF, 2'b00);
    join_none
    repeat (4) @(negedge aclk);
    chk("stall_pending", pend32, 4);
    chk("stall_awready", b32.awready, 0);
    chk("stall_wready", b32.wready, 0);
    @(posedge aclk);
    #1 stall = 1'b0;
    drain();

    // B channel backpressure
    b32.bready = 1'b0;
    wr32(32'h40, 32'h11, 4'hF, 0, 0, 4'hF, 2'b00);
    wr32(32'h41, 32'h22, 4'hF, 0, 0, 4'h0, 2'b10);
    wr32(32'h2000, 32'h33, 4'hF, 0, 0, 4'h0, 2'b11);
    repeat (4) @(negedge aclk);
    chk("bp_pending", pend32, 2);
    chk("bp_bvalid", b32.bvalid, 1);
    chk("bp_bresp", b32.bresp, 2'b00);
    @(posedge aclk);
    #1 b32.bready = 1'b1;
    drain();

    // 64-bit lane
    wr64(32'h8, 64'h1122334455667788, 8'h0F, 8'h0F, 2'b00);
    wr64(32'h4, 64'h99AABBCCDDEEFF00, 8'hFF, 8'h00, 2'b10);
    drain();

    // reset with two queued writes and a response outstanding
    b32.bready = 1'b0;
    wr32(32'h50, 32'h51, 4'hF, 0, 0, 4'hF, 2'b00);
    wr32(32'h54, 32'h55, 4'hF, 0, 0, 4'hF, 2'b00);
    wr32(32'h58, 32'h59, 4'hF, 0, 0, 4'hF, 2'b00);
    repeat (4) @(posedge aclk);
    #1;
    chk("pre_rst_pending", pend32, 2);
    aresetn = 1'b0;
    #1;
    q32.delete();
    chk("mid_rst_bvalid", b32.bvalid, 0);
    chk("mid_rst_pending", pend32, 0);
    chk("mid_rst_en", en32, 0);
    chk("mid_rst_addr", addr32, 0);
    chk("mid_rst_data", data32, 0);
    chk("mid_rst_awready", b32.awready, 0);
    b32.bready = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    wr32(32'h60, 32'h600DF00D, 4'hC, 0, 0, 4'hC, 2'b00);
    drain();
    repeat (10) @(posedge aclk);
    chk("leftover32", q32.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_write_slave_q.md
# axi4lite_write_slave_q

Parametrised AXI4-Lite write-channel slave with a command queue between the bus and a local register/memory write port. AW and W beats are captured independently, paired, range-checked and queued DEPTH deep, so the bus keeps accepting writes while the backend stalls. Each queued write drives a one-cycle byte-enable strobe to the backend and returns its B response in order. It sits between the AXI4-Lite interconnect and a peripheral register file or SRAM.

## Interface
- DATA_W, 32, data width; 32 or 64
- ADDR_W, 32, address width
- DEPTH, 4, command queue depth; power of 2, >= 2
- BASE, 0, first decoded byte address
- SIZE, 4096, decoded window size in bytes
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- awvalid / awready  in / out  1  write-address handshake
- awaddr  in  ADDR_W  write address
- awprot  in  3  ignored
- wvalid / wready  in / out  1  write-data handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte strobes
- bvalid / bready  out / in  1  response handshake
- bresp  out  2  response: OKAY 00, SLVERR 10, DECERR 11
- stall  in  1  backend busy; blocks queue pop
- en  out  DATA_W/8  byte write enables; one-cycle pulse
- addr  out  ADDR_W  backend address, held until next pop
- data  out  DATA_W  backend data, held until next pop
- pending  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- AW hold register: awready=1 means empty. Handshake (awvalid&awready) captures awaddr and sets awready=0 next cycle. W hold register behaves the same with wdata/wstrb.
- Push: both holds full and pending<DEPTH. Entry {addr, data, strb, resp} is written. Both holds clear, and awready=wready=1 the following cycle.
- Response code, computed at push, priority order:
  - DECERR if addr<BASE or addr>=BASE+SIZE
  - else SLVERR if addr[log2(DATA_W/8)-1:0]!=0
  - else OKAY
- Pop: pending>0 & ~stall & (~bvalid | bready). On the pop edge:
  - addr, data <= entry
  - en <= entry strb if resp==OKAY, else 0
  - bvalid <= 1, bresp <= entry resp
- en is 0 in every cycle without a pop. wstrb=0 with OKAY pops with en=0 and bresp=OKAY.
- bvalid clears on bready when no pop occurs in the same cycle. Pop with bvalid&bready makes bvalid stay 1 with the new bresp.
- Responses are in strict push order. There is no reordering and no AW/W cross-pairing beyond FIFO order.
- Same-cycle push and pop: pending unchanged. Full test uses pre-edge pending, with no bypass. Push at pending==DEPTH waits even if a pop occurs in that cycle.
- Reset, including mid-transaction, clears:
  - holds, queue and pending=0
  - awready=wready=0, bvalid=0, bresp=OKAY
  - en=0, addr=0, data=0
  - Queued or in-flight writes are dropped with no response.

## Timing
- awready and wready are 0 during reset and go 1 on the first edge after release.
- Minimum accept-to-en latency, stall=0: handshake edge T → push T+1 → pop T+2, so en and bvalid are high in cycle T+2.
- Input throughput is one write per 2 cycles (hold, then push). Output throughput is one pop per cycle while bready=1 and stall=0.
- With stall=1 the bus still fills DEPTH entries plus one held AW/W pair. After that awready=wready=0 until a pop frees a slot.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Single write, awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, AW and W in the same cycle, stall=0, bready=1 → en=0xF for exactly one cycle, addr=0x10, data=0xDEADBEEF, bresp=OKAY, bvalid for one cycle.
- W two cycles before AW; awaddr=0x2 → en stays 0, bresp=SLVERR. awaddr=BASE+SIZE → bresp=DECERR, en=0.
- stall=1, issue 6 writes with DEPTH=4 → pending reaches 4, awready=wready=0 after 5 accepted. Release stall → 5 en pulses in address order, then the 6th write is accepted.
- bready=0 with 3 queued writes → one pop, then bvalid holds with bresp stable and no further en. Pulse bready each cycle → one pop per cycle, back-to-back bvalid.
- Deassert aresetn with 2 entries queued and bvalid=1 → all outputs at reset values immediately. After release no stale response appears, and a new write completes normally.
- DATA_W=64, awaddr=0x8, wstrb=0x0F → en=0x0F. awaddr=0x4 → SLVERR.
